// File: rtl/ram_4096_master.sv
// ram_4096_master: burst command controller for the 4096x64 RAM with a credit-limited response FIFO.
// Optional statistics counters are enabled with `define RAM_MASTER_STATS_EN.
module ram_4096_master #(
  parameter int RAM_WIDTH = 64,
  parameter int ADDR_SIZE = 12,
  parameter int LEN_W = 8,
  parameter int RD_LAT = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 wdat_valid,
  output logic                 wdat_ready,
  input  logic [RAM_WIDTH-1:0] wdat,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RAM_WIDTH-1:0] rsp_data,
  output logic                 rsp_last,
  output logic                 busy,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  output logic [ADDR_SIZE-1:0] ram_rd_address,
  output logic [ADDR_SIZE-1:0] ram_wr_address,
  output logic                 ram_read,
  output logic                 ram_write,
`ifdef RAM_MASTER_STATS_EN
  output logic [31:0]          stat_wr_cnt,
  output logic [31:0]          stat_rd_cnt,
`endif
  input  logic [RAM_WIDTH-1:0] ram_data_out
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t state;
  logic [ADDR_SIZE-1:0] addr;
  logic [LEN_W-1:0] cnt;
  logic rd_last;
  logic [RD_LAT-1:0] pipe_v, pipe_l;
  logic [RAM_WIDTH-1:0] fifo_d [RSP_DEPTH];
  logic fifo_l [RSP_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [7:0] inflight;
  logic wr_hs, issue, push, pop;
  assign cmd_ready = state == IDLE && !rst;
  assign wdat_ready = state == WR;
  assign wr_hs = wdat_ready && wdat_valid;
  assign rsp_valid = count != '0;
  assign rsp_data = rsp_valid ? fifo_d[rp] : '0;
  assign rsp_last = rsp_valid && fifo_l[rp];
  assign push = pipe_v[RD_LAT-1];
  assign pop = rsp_valid && rsp_ready;
  assign busy = state != IDLE || inflight != '0 || rsp_valid;
  // ram_read counts as in flight until it enters the latency pipe
  always_comb begin
    inflight = 8'(ram_read);
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 8'(pipe_v[i]);
  end
  assign issue = state == RD && (8'(count) + inflight < 8'(RSP_DEPTH));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      ram_data_in <= '0;
      ram_rd_address <= '0;
      ram_wr_address <= '0;
      ram_read <= 1'b0;
      ram_write <= 1'b0;
      rd_last <= 1'b0;
      pipe_v <= '0;
      pipe_l <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      ram_write <= wr_hs;
      ram_read <= issue;
      rd_last <= issue && cnt == '0;
      if (wr_hs) begin
        ram_wr_address <= addr;
        ram_data_in <= wdat;
      end
      if (issue) ram_rd_address <= addr;
      pipe_v <= (pipe_v << 1) | RD_LAT'(ram_read);
      pipe_l <= (pipe_l << 1) | RD_LAT'(ram_read && rd_last);
      if (state == IDLE && cmd_valid) begin
        addr <= cmd_addr;
        cnt <= cmd_len;
        state <= cmd_write ? WR : RD;
      end else if (wr_hs || issue) begin
        addr <= addr + 1'b1;
        cnt <= cnt - 1'b1;
        if (cnt == '0) state <= IDLE;
      end
      if (push) begin
        fifo_d[wp] <= ram_data_out;
        fifo_l[wp] <= pipe_l[RD_LAT-1];
        wp <= wp == PW'(RSP_DEPTH - 1) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= rp == PW'(RSP_DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
`ifdef RAM_MASTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else begin
      stat_wr_cnt <= stat_wr_cnt + 32'(ram_write);
      stat_rd_cnt <= stat_rd_cnt + 32'(pop);
    end
  end
`endif
endmodule

// File: tb/tb_ram_4096_master.sv
// tb_ram_4096_master: directed bench for ram_4096_master with a behavioural RD_LAT=1 RAM.
module tb_ram_4096_master;
  logic clk = 0;
  logic rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [11:0] cmd_addr = 0;
  logic [7:0] cmd_len = 0;
  logic wdat_valid = 0, wdat_ready;
  logic [63:0] wdat = 0;
  logic rsp_valid, rsp_ready = 1, rsp_last, busy;
  logic [63:0] rsp_data, ram_data_in, ram_data_out;
  logic [11:0] ram_rd_address, ram_wr_address;
  logic ram_read, ram_write;
`ifdef RAM_MASTER_STATS_EN
  logic [31:0] stat_wr_cnt, stat_rd_cnt;
`endif
  int total = 0, bad = 0, cyc = 0;
  logic [63:0] mem [4096];
  logic [11:0] wa_q[$], ra_q[$];
  logic [63:0] wd_q[$], rd_q[$];
  logic rl_q[$];
  int rc_q[$];

  always #5 clk = ~clk;

  ram_4096_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy), .ram_data_in(ram_data_in),
    .ram_rd_address(ram_rd_address), .ram_wr_address(ram_wr_address),
    .ram_read(ram_read), .ram_write(ram_write),
`ifdef RAM_MASTER_STATS_EN
    .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
`endif
    .ram_data_out(ram_data_out)
  );

  always @(posedge clk) begin
    if (ram_write) mem[ram_wr_address] <= ram_data_in;
    if (ram_read) ram_data_out <= mem[ram_rd_address];
  end

  always @(negedge clk) begin
    cyc++;
    if (ram_write) begin
      wa_q.push_back(ram_wr_address);
      wd_q.push_back(ram_data_in);
    end
    if (ram_read) begin
      ra_q.push_back(ram_rd_address);
      rc_q.push_back(cyc);
    end
    if (rsp_valid && rsp_ready) begin
      rd_q.push_back(rsp_data);
      rl_q.push_back(rsp_last);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); ra_q.delete(); rc_q.delete(); rd_q.delete(); rl_q.delete();
  endtask

  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [7:0] l);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("cmd_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    wdat_valid = 1; wdat = d;
    while (!wdat_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("wdat_timeout", 0, 1);
    @(posedge clk);
    #1 wdat_valid = 0;
  endtask

  task automatic wr_burst(input logic [11:0] a, input logic [7:0] l, input logic [63:0] base);
    send_cmd(1, a, l);
    for (int i = 0; i <= int'(l); i++) send_beat(base + 64'(i));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rd_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("rsp_count", 64'(rd_q.size()), 64'(n));
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_ram_read", ram_read, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rd_addr", ram_rd_address, 0);
    check("rst_data_in", ram_data_in, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_wdat_ready", wdat_ready, 0);

    clear_logs();
    wr_burst(12'h005, 0, 64'hDEAD_BEEF_0000_0001);
    check("w1_beats", 64'(wa_q.size()), 1);
    check("w1_addr", wa_q[0], 12'h005);
    check("w1_data", wd_q[0], 64'hDEAD_BEEF_0000_0001);
    check("w1_idle", cmd_ready, 1);
    check("w1_busy", busy, 0);

    wr_burst(12'h100, 3, 64'h1000);
    clear_logs();
    send_cmd(0, 12'h100, 3);
    wait_rsp(4);
    check("rd_issues", 64'(ra_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check("rd_addr", ra_q[i], 12'h100 + 12'(i));
      check("rd_consec", 64'(rc_q[i] - rc_q[0]), 64'(i));
      check("rd_data", rd_q[i], 64'h1000 + 64'(i));
      check("rd_last", rl_q[i], i == 3);
    end

    clear_logs();
    wr_burst(12'hFFE, 3, 64'hA5A5_0000_0000_0000);
    check("wrap_beats", 64'(wa_q.size()), 4);
    check("wrap_a0", wa_q[0], 12'hFFE);
    check("wrap_a1", wa_q[1], 12'hFFF);
    check("wrap_a2", wa_q[2], 12'h000);
    check("wrap_a3", wa_q[3], 12'h001);
    clear_logs();
    send_cmd(0, 12'hFFE, 3);
    wait_rsp(4);
    for (int i = 0; i < 4; i++) check("wrap_data", rd_q[i], 64'hA5A5_0000_0000_0000 + 64'(i));
    check("wrap_last", rl_q[3], 1);

    wr_burst(12'h200, 7, 64'h2000);
    clear_logs();
    #1 rsp_ready = 0;
    send_cmd(0, 12'h200, 7);
    repeat (20) @(negedge clk);
    check("bp_issues", 64'(ra_q.size()), 4);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_busy", busy, 1);
    @(posedge clk);
    #1 rsp_ready = 1;
    wait_rsp(8);
    repeat (5) @(negedge clk);
    check("bp_total", 64'(rd_q.size()), 8);
    for (int i = 0; i < 8; i++) begin
      check("bp_data", rd_q[i], 64'h2000 + 64'(i));
      check("bp_last", rl_q[i], i == 7);
    end
    check("bp_idle_busy", busy, 0);

    clear_logs();
    send_cmd(0, 12'h200, 7);
    for (int k = 0; ra_q.size() < 2 && k < 50; k++) @(negedge clk);
    pulse_rst();
    @(negedge clk);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_ram_read", ram_read, 0);
    repeat (4) @(negedge clk);
    check("mr_rsp_valid2", rsp_valid, 0);
    clear_logs();
    send_cmd(0, 12'h005, 0);
    wait_rsp(1);
    repeat (5) @(negedge clk);
    check("mr_count", 64'(rd_q.size()), 1);
    check("mr_data", rd_q[0], 64'hDEAD_BEEF_0000_0001);
    check("mr_last", rl_q[0], 1);

`ifdef RAM_MASTER_STATS_EN
    pulse_rst();
    clear_logs();
    wr_burst(12'h300, 2, 64'h3000);
    send_cmd(0, 12'h300, 4);
    wait_rsp(5);
    repeat (3) @(negedge clk);
    check("stat_wr", stat_wr_cnt, 3);
    check("stat_rd", stat_rd_cnt, 5);
    pulse_rst();
    @(negedge clk);
    check("stat_wr_rst", stat_wr_cnt, 0);
    check("stat_rd_rst", stat_rd_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_4096_master.md
Name: ram_4096_master

Overview:
- Initiator-side controller for the 4096x64 banked RAM.
- Accepts burst read/write commands from a client over valid/ready handshakes and drives the RAM's data_in, rd_address, wr_address, read and write.
- Captures RAM read data after a fixed latency and returns it to the client through a backpressured response FIFO.
- Sits between the RAM array and any datapath client; it is the only driver of the RAM's control pins.

Parameters:
- RAM_WIDTH, 64, data word width.
- ADDR_SIZE, 12, word address width (4096 words).
- LEN_W, 8, burst length field width; a burst is cmd_len+1 beats.
- RD_LAT, 1, cycles from a RAM read issue edge to valid ram_data_out; range 1..4.
- RSP_DEPTH, 4, response FIFO depth; must be >= RD_LAT+1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_SIZE  burst start address.
- cmd_len  in  LEN_W  beats minus one.
- wdat_valid  in  1  write beat offered.
- wdat_ready  out  1  write beat accepted.
- wdat  in  RAM_WIDTH  write beat data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  client consumes rsp_data.
- rsp_data  out  RAM_WIDTH  read data.
- rsp_last  out  1  final beat of a read burst.
- busy  out  1  burst active, reads in flight, or FIFO non-empty.
- ram_data_in  out  RAM_WIDTH  to RAM data_in.
- ram_rd_address  out  ADDR_SIZE  to RAM rd_address.
- ram_wr_address  out  ADDR_SIZE  to RAM wr_address.
- ram_read  out  1  to RAM read.
- ram_write  out  1  to RAM write.
- ram_data_out  in  RAM_WIDTH  from RAM data_out.

Behaviour:
- Reset (clk edge with rst=1): state IDLE; FIFO, in-flight pipe and counters cleared. Outputs: cmd_ready=0 during reset and 1 in the first IDLE cycle after; wdat_ready, rsp_valid, rsp_last, ram_read, ram_write, busy=0; all addresses and data outputs 0.
- Reset mid-burst: remaining beats are abandoned. Read data already in flight is discarded and never reaches the FIFO.
- RAM model the block relies on:
  - write: RAM stores ram_data_in at ram_wr_address on the edge where ram_write=1.
  - read: RAM samples ram_rd_address on the edge where ram_read=1; ram_data_out is valid and captured RD_LAT edges later.
- FSM states IDLE, WR, RD:
  - IDLE: cmd_ready=1. On handshake, latch address and remaining count=cmd_len; go to WR if cmd_write, else RD.
  - WR: wdat_ready=1. On each wdat handshake, the same edge registers ram_write=1, ram_wr_address=current address, ram_data_in=wdat. Address then increments. The last beat returns to IDLE. With no beat offered, ram_write=0 next cycle.
  - RD: issue one read per cycle while FIFO count + in-flight < RSP_DEPTH. Registered outputs on issue: ram_read=1, ram_rd_address=current address. The last issue returns to IDLE, so a new command may be accepted while reads are still in flight.
- Address arithmetic: modulo 2^ADDR_SIZE; 4095 wraps to 0 within a burst.
- In-flight tracking: an RD_LAT-deep shift pipe of {valid, last}. The last bit is set on the final issue of a burst. At pipe exit, ram_data_out and last are pushed into the FIFO.
- Credit rule: the FIFO can never overflow and never drops data.
- FIFO output:
  - rsp_valid = not empty; rsp_data/rsp_last come from the head entry.
  - Pop on rsp_valid&rsp_ready.
  - Push and pop in the same cycle are both performed.
- Read ordering: read data always returns in issue order.
- Write-then-read to the same address: the read command is accepted only after WR completes, so the read returns the new data.
- busy = (state!=IDLE) | any in-flight | FIFO non-empty.

Optional Feature:
- Macro: RAM_MASTER_STATS_EN.
- Defined: adds outputs stat_wr_cnt and stat_rd_cnt, 32 bits each.
  - stat_wr_cnt increments per ram_write beat.
  - stat_rd_cnt increments per response pop.
  - Both wrap at 2^32 and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then single write: cmd(write, addr=0x005, len=0), wdat=0xDEAD_BEEF_0000_0001 -> one cycle with ram_write=1, ram_wr_address=0x005, ram_data_in=0xDEAD_BEEF_0000_0001; back in IDLE.
- Read burst: addr=0x100, len=3 -> ram_read for 4 consecutive cycles at 0x100..0x103; 4 responses in order, rsp_last only on the 4th.
- Wrap: write burst addr=0xFFE, len=3 -> addresses 0xFFE, 0xFFF, 0x000, 0x001; a read back returns the identical 4 words.
- Backpressure: read burst len=7 with rsp_ready=0 -> issues stop after RSP_DEPTH outstanding (4). Raising rsp_ready -> all 8 words delivered, none lost or duplicated.
- Reset mid-operation: rst asserted for 1 cycle during beat 2 of a len=7 read burst -> rsp_valid=0 and busy=0 afterwards; no stale data appears on the next read.
- RAM_MASTER_STATS_EN: 3 writes then 5 reads consumed -> stat_wr_cnt=3, stat_rd_cnt=5; after rst both are 0.
